// File: rtl/generic_fifo_pkg.sv
// Shared definitions for the generic single-clock FIFO family.
package generic_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_NORMAL = 0;
  localparam int FIFO_MODE_FWFT   = 1;

  // Status flags derived from the registered level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Ceiling log2, used to size the level counter so it can hold 0..DEPTH.
  function automatic int fifo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/generic_fifo_sc_if.sv
// Handshake and status bundle between a FIFO and its user.
interface generic_fifo_sc_if #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 3
);

  logic              wen;
  logic [DWIDTH-1:0] wdata;
  logic              ren;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   level;
  logic              overflow;
  logic              underflow;

  // The user side: issues writes and reads, observes data and status.
  modport master (
    output wen, wdata, ren,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  // The FIFO side: accepts requests, drives data and status.
  modport slave (
    input  wen, wdata, ren,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/generic_sdp_ram.sv
// Single-clock simple dual-port RAM: synchronous write, registered read
// with read enable. Only the read register is reset so the FIFO output
// starts at zero; the storage array itself is never cleared.
module generic_sdp_ram #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Capture the addressed word only when a read is issued, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/generic_fifo_sc.sv
// Single-clock FIFO built around generic_sdp_ram. Owns the read/write
// pointers, the occupancy level, the status flags, the overflow/underflow
// pulses and, in first-word-fall-through mode, the head-word prefetch.
module generic_fifo_sc
  import generic_fifo_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int AWIDTH     = 3,
  parameter int FWFT       = FIFO_MODE_NORMAL,
  parameter int AFULL_LVL  = (1 << AWIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input logic              clk,
  input logic              rst_n,
  generic_fifo_sc_if.slave bus
);

  localparam int DEPTH   = 1 << AWIDTH;
  localparam int LWIDTH  = fifo_clog2(DEPTH + 1);
  localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  // Pointers carry one extra wrap bit so DEPTH words can be told from zero.
  logic [AWIDTH:0]   wptr;
  logic [AWIDTH:0]   rptr;
  logic [AWIDTH:0]   ram_count;
  logic [LWIDTH-1:0] level_q;
  logic              rvalid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              wr_ok;
  logic              rd_ok;
  logic              ram_re;
  logic              underflow_cond;
  logic [DWIDTH-1:0] ram_q;
  fifo_flags_t       flags;

  // Words sitting in the RAM that have not yet been pulled out by a read.
  assign ram_count = wptr - rptr;

  // Flags come straight from the registered level so they move one cycle
  // after the write or read that changed it.
  always_comb begin
    flags              = '0;
    flags.full         = (level_q == LWIDTH'(DEPTH));
    flags.empty        = (level_q == '0);
    flags.almost_full  = (int'(level_q) >= AFULL_LVL);
    flags.almost_empty = (int'(level_q) <= AEMPTY_LVL);
  end

  // A write is gated by the registered full flag only, so a read in the
  // same cycle cannot free a slot for it.
  assign wr_ok = bus.wen & ~flags.full;

  // Read acceptance and RAM read issue differ by mode. In normal mode the
  // RAM read is the read. In FWFT mode a read consumes the head register,
  // and the RAM is read to refill that register whenever it is empty or
  // being consumed and the RAM still holds words.
  always_comb begin
    rd_ok          = 1'b0;
    ram_re         = 1'b0;
    underflow_cond = 1'b0;
    if (IS_FWFT) begin
      rd_ok          = bus.ren & rvalid_q;
      ram_re         = (ram_count != '0) & (~rvalid_q | rd_ok);
      underflow_cond = bus.ren & ~rvalid_q;
    end else begin
      rd_ok          = bus.ren & ~flags.empty;
      ram_re         = rd_ok;
      underflow_cond = bus.ren & flags.empty;
    end
  end

  // Advance the write pointer on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wr_ok) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Advance the read pointer whenever a word leaves the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else if (ram_re) begin
      rptr <= rptr + 1'b1;
    end
  end

  // Level counts every word the FIFO is responsible for, including the
  // FWFT head register; a simultaneous write and read leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (wr_ok && !rd_ok) begin
      level_q <= level_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      level_q <= level_q - 1'b1;
    end
  end

  // rvalid marks a fresh read result in normal mode, and head-register
  // occupancy in FWFT mode (filled by a RAM read, cleared when consumed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
    end else if (IS_FWFT) begin
      if (ram_re) begin
        rvalid_q <= 1'b1;
      end else if (rd_ok) begin
        rvalid_q <= 1'b0;
      end
    end else begin
      rvalid_q <= rd_ok;
    end
  end

  // Single-cycle error pulses for rejected writes and reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.wen & flags.full;
      underflow_q <= underflow_cond;
    end
  end

  // The RAM read register doubles as the output data register (and as the
  // head register in FWFT mode), which keeps normal-mode latency at one.
  generic_sdp_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr[AWIDTH-1:0]),
    .wdata (bus.wdata),
    .re    (ram_re),
    .raddr (rptr[AWIDTH-1:0]),
    .rdata (ram_q)
  );

  assign bus.rdata        = ram_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_generic_fifo_sc.sv
// Bench for generic_fifo_sc: a normal-mode and an FWFT-mode instance share
// one stimulus stream and are each compared against a queue-based model.
module tb_generic_fifo_sc;

  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } fwft_entry_t;

  typedef struct {
    logic          wen;
    logic [DW-1:0] wdata;
    logic          ren;
    int            lvl;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          ovf;
    logic          unf;
  } vec_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wen   = 1'b0;
  logic          ren   = 1'b0;
  logic [DW-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: normal-mode model
  logic [DW-1:0] nq[$];
  logic [DW-1:0] n_rdata;
  logic          n_rvalid, n_ovf, n_unf;
  // Reference state: FWFT model, each word tagged with the cycle it may show
  fwft_entry_t   fq[$];
  logic          f_ovf, f_unf;

  vec_t vecs[$];

  generic_fifo_sc_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_n ();
  generic_fifo_sc_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_f ();

  assign bus_n.wen   = wen;
  assign bus_n.wdata = wdata;
  assign bus_n.ren   = ren;
  assign bus_f.wen   = wen;
  assign bus_f.wdata = wdata;
  assign bus_f.ren   = ren;

  generic_fifo_sc #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  generic_fifo_sc #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(1)) dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h cycle=%0d",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic f_head_valid();
    if (fq.size() == 0) return 1'b0;
    return (fq[0].avail <= cyc);
  endfunction

  function automatic void model_reset();
    nq.delete();
    fq.delete();
    n_rdata  = '0;
    n_rvalid = 1'b0;
    n_ovf    = 1'b0;
    n_unf    = 1'b0;
    f_ovf    = 1'b0;
    f_unf    = 1'b0;
  endfunction

  // Advance both models by one clock using the inputs of the current cycle
  function automatic void model_step(input logic w, input logic [DW-1:0] d,
                                     input logic r);
    logic        n_wr, n_rd, f_wr, fvalid;
    fwft_entry_t head;
    // normal mode: plain FIFO queue, read data returned one cycle later
    n_wr     = w && (nq.size() != DEPTH);
    n_rd     = r && (nq.size() != 0);
    n_ovf    = w && (nq.size() == DEPTH);
    n_unf    = r && (nq.size() == 0);
    n_rvalid = n_rd;
    if (n_rd) n_rdata = nq.pop_front();
    if (n_wr) nq.push_back(d);
    // FWFT: a word shows two cycles after its write, or one cycle after
    // the previous head was consumed, whichever is later
    fvalid = f_head_valid();
    f_wr   = w && (fq.size() != DEPTH);
    f_ovf  = w && (fq.size() == DEPTH);
    f_unf  = r && !fvalid;
    if (r && fvalid) begin
      head = fq.pop_front();
      if (fq.size() > 0) begin
        head = fq.pop_front();
        if (head.avail < cyc + 1) head.avail = cyc + 1;
        fq.push_front(head);
      end
    end
    if (f_wr) fq.push_back('{data: d, avail: cyc + 2});
    cyc++;
  endfunction

  task automatic checkOutput();
    logic fv;
    check_val("n_level",  bus_n.level,        nq.size());
    check_val("n_full",   bus_n.full,         nq.size() == DEPTH);
    check_val("n_empty",  bus_n.empty,        nq.size() == 0);
    check_val("n_afull",  bus_n.almost_full,  nq.size() >= AFULL);
    check_val("n_aempty", bus_n.almost_empty, nq.size() <= AEMPTY);
    check_val("n_rvalid", bus_n.rvalid,       n_rvalid);
    check_val("n_rdata",  bus_n.rdata,        n_rdata);
    check_val("n_ovf",    bus_n.overflow,     n_ovf);
    check_val("n_unf",    bus_n.underflow,    n_unf);
    fv = f_head_valid();
    check_val("f_level",  bus_f.level,        fq.size());
    check_val("f_full",   bus_f.full,         fq.size() == DEPTH);
    check_val("f_empty",  bus_f.empty,        fq.size() == 0);
    check_val("f_afull",  bus_f.almost_full,  fq.size() >= AFULL);
    check_val("f_aempty", bus_f.almost_empty, fq.size() <= AEMPTY);
    check_val("f_rvalid", bus_f.rvalid,       fv);
    if (fv) check_val("f_rdata", bus_f.rdata, fq[0].data);
    check_val("f_ovf",    bus_f.overflow,     f_ovf);
    check_val("f_unf",    bus_f.underflow,    f_unf);
  endtask

  // Drive one cycle of inputs, clock it, then compare at the falling edge
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d,
                               input logic r);
    wen   = w;
    wdata = d;
    ren   = r;
    model_step(w, d, r);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    wen   = 1'b0;
    ren   = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput();
    check_val("rst_n_level",  bus_n.level,        0);
    check_val("rst_n_empty",  bus_n.empty,        1);
    check_val("rst_n_aempty", bus_n.almost_empty, 1);
    check_val("rst_f_level",  bus_f.level,        0);
    check_val("rst_f_empty",  bus_f.empty,        1);
    check_val("rst_f_rvalid", bus_f.rvalid,       0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add_vec(input logic w, input logic [DW-1:0] d,
                                  input logic r, input int lvl,
                                  input logic rv, input logic [DW-1:0] rd,
                                  input logic ovf, input logic unf);
    vecs.push_back('{wen: w, wdata: d, ren: r, lvl: lvl, rvalid: rv,
                     rdata: rd, ovf: ovf, unf: unf});
  endfunction

  initial begin
    vec_t v;
    int   wp;

    // Directed normal-mode table: fill, overflow, drain, empty read+write
    for (int i = 1; i <= 8; i++) add_vec(1'b1, 8'(i), 1'b0, i, 1'b0, 8'h00, 1'b0, 1'b0);
    add_vec(1'b1, 8'hFF, 1'b0, 8, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) add_vec(1'b0, 8'h00, 1'b1, 8 - i, 1'b1, 8'(i), 1'b0, 1'b0);
    add_vec(1'b1, 8'hAA, 1'b1, 1, 1'b0, 8'h08, 1'b0, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h08, 1'b0, 1'b0);

    model_reset();
    #2;
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.wen, v.wdata, v.ren);
      check_val("tbl_level",  bus_n.level,        v.lvl);
      check_val("tbl_full",   bus_n.full,         v.lvl == DEPTH);
      check_val("tbl_empty",  bus_n.empty,        v.lvl == 0);
      check_val("tbl_afull",  bus_n.almost_full,  v.lvl >= AFULL);
      check_val("tbl_aempty", bus_n.almost_empty, v.lvl <= AEMPTY);
      check_val("tbl_rvalid", bus_n.rvalid,       v.rvalid);
      check_val("tbl_rdata",  bus_n.rdata,        v.rdata);
      check_val("tbl_ovf",    bus_n.overflow,     v.ovf);
      check_val("tbl_unf",    bus_n.underflow,    v.unf);
    end

    // Concurrent write/read at level 4 across the pointer wrap
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      check_val("conc_n_level", bus_n.level, 4);
      check_val("conc_f_level", bus_f.level, 4);
    end

    // FWFT: single write shows two cycles later, then sustained streaming
    doReset();
    applyStimulus(1'b1, 8'h55, 1'b0);
    check_val("fwft_t1_rvalid", bus_f.rvalid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    check_val("fwft_t2_rvalid", bus_f.rvalid, 1);
    check_val("fwft_t2_rdata",  bus_f.rdata,  8'h55);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h70 + i), 1'b1);
      check_val("stream_rvalid", bus_f.rvalid,    1);
      check_val("stream_unf",    bus_f.underflow, 0);
      check_val("stream_rdata",  bus_f.rdata, (i < 3) ? 8'(8'h60 + i) : 8'(8'h70 + i - 3));
    end

    // Reset in the middle of a burst discards everything held
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0);
    check_val("burst_level", bus_n.level, 5);
    doReset();
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    check_val("post_rst_rvalid", bus_n.rvalid, 1);
    check_val("post_rst_rdata",  bus_n.rdata,  8'hC3);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Random traffic with alternating bias to reach both full and empty
    wp = 70;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) wp = (wp == 70) ? 30 : 70;
      applyStimulus($urandom_range(0, 99) < wp, 8'($urandom),
                    $urandom_range(0, 99) < (100 - wp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/generic_fifo_sc.md
Name: generic_fifo_sc

Overview:
- Single-clock, parametrised FIFO for the MAC datapath: small elastic buffers such as loop-back, pause-frame and statistics queues.
- Next generation of the small generic memory: RAM plus its own pointer, level and flag logic.
- Two read modes: normal (registered read, 1-cycle latency) and first-word-fall-through (FWFT).
- Provides overflow/underflow detection and programmable almost-full/almost-empty thresholds.

Parameters:
- DWIDTH, 64, data word width in bits.
- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH words.
- FWFT, 0, 0 = normal read (rdata valid 1 cycle after accepted ren); 1 = head word presented on rdata with rvalid.
- AFULL_LVL, DEPTH-2, almost_full asserted when level >= AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserted when level <= AEMPTY_LVL.

Ports:
- clk  in  1  FIFO clock.
- rst_n  in  1  asynchronous active-low reset.
- wen  in  1  write request.
- wdata  in  DWIDTH  write data.
- ren  in  1  read request (normal mode) / head acknowledge (FWFT).
- rdata  out  DWIDTH  read data.
- rvalid  out  1  rdata valid.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_LVL.
- almost_empty  out  1  level <= AEMPTY_LVL.
- level  out  AWIDTH+1  words held.
- overflow  out  1  one-cycle pulse: wen while full.
- underflow  out  1  one-cycle pulse: ren while empty (normal) or while !rvalid (FWFT).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0 except empty = 1 and almost_empty = 1. Pointers and level cleared. RAM contents are not reset.
- Reset mid-operation: all stored words are discarded; the first write after release lands at address 0.
- Pointers: wptr and rptr are AWIDTH+1 bits with an extra wrap bit. RAM is addressed by the low AWIDTH bits; pointers wrap naturally from DEPTH-1 to 0.
- Write accept: wr_ok = wen & !full. Writes the RAM at wptr, then increments wptr.
- Write while full: ignored, overflow pulses, no state change.
- Write accept with read in the same cycle: the registered full flag governs, so a write is blocked when full even if a read is accepted in that cycle.
- Normal mode (FWFT=0):
  - Read accept: rd_ok = ren & !empty. The RAM read is registered; rdata updates and rvalid = 1 in the next cycle.
  - rdata holds its last value when no read is accepted; rvalid is then 0.
  - ren while empty: underflow pulses, rvalid = 0 next cycle.
  - Simultaneous wen/ren while empty: the write is accepted, the read is rejected with underflow.
- FWFT mode (FWFT=1):
  - A one-word output register holds the head word; rvalid = output register occupied.
  - The register is loaded from RAM whenever it is empty or being consumed (ren & rvalid) and RAM holds data.
  - A word written into an empty FIFO appears on rdata with rvalid = 1 two cycles after the write cycle.
  - ren & rvalid consumes the head; back-to-back consumption sustains 1 word/cycle.
  - ren & !rvalid: underflow pulse, no state change.
- Level: counts every word held, including the FWFT output register and in-flight RAM read.
  - level_next = level + wr_ok - rd_ok; simultaneous accept leaves it unchanged.
  - All flags derive from the registered level and update the cycle after the causing event.
- Capacity: exactly DEPTH words in both modes; the RAM can never be overwritten before it is read.

Decomposition:
- Shared package generic_fifo_pkg:
  - Read-mode constants FIFO_MODE_NORMAL = 0 and FIFO_MODE_FWFT = 1.
  - A clog2 helper for level width.
- Sub-module generic_sdp_ram: single-clock simple dual-port RAM (DWIDTH, AWIDTH) with synchronous write and registered read with read enable.
- generic_fifo_sc owns the pointers, level, flags, FWFT prefetch and error pulses.

Test Plan:
- Reset, then 8 writes 0x01..0x08 (AWIDTH=3, FWFT=0) -> full=1 and level=8 after the last write; almost_full asserts once level reaches 6.
- With the FIFO full, wen with 0xFF -> overflow pulses one cycle, level stays 8; 8 reads return 0x01..0x08 in order, each 1 cycle after ren; empty=1 at the end.
- Empty FIFO, ren -> underflow pulse, rvalid=0; same cycle also wen 0xAA -> level=1, empty=0, no read occurs.
- Run 20 concurrent wen/ren cycles at level 4 -> level constant at 4, data order preserved across pointer wrap (addresses 7->0).
- FWFT=1: single write 0x55 at cycle t -> rvalid=1 and rdata=0x55 at t+2. Then stream 16 words with ren held high -> one word per cycle, no gaps, no underflow.
- Assert rst_n low with level=5 mid-burst -> all flags/level return to reset values immediately; the next write/read returns the new data, not stale words.
